write_port_selector: RTL

//  Downstream of the write-arbiter priority decoder: consumes its latched per-port priority and

---
 rtl/write_arb_pkg.sv | 21 ++
 rtl/prio_rr_pick.sv | 47 ++++
 rtl/write_port_selector.sv | 126 ++++++++++++
 3 files changed

// File: rtl/write_arb_pkg.sv
// ----------------------------------------------------------------------------
// write_arb_pkg: shared FSM encoding and field widths of the write arbiter.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package write_arb_pkg;
  localparam int priority_width    = 3;
  localparam int pack_length_width = 7;
  localparam int des_port_width    = 4;
  localparam int select_width      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ARB  = 2'd2,
    XFER = 2'd3
  } arb_state_t;
endpackage

`default_nettype wire

// File: rtl/prio_rr_pick.sv
// ----------------------------------------------------------------------------
// prio_rr_pick: highest-priority requester, ties broken from start ptr upward.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module prio_rr_pick #(
  parameter int num_of_ports = 16,
  parameter int prio_w       = write_arb_pkg::priority_width
) (
  input  logic [num_of_ports*prio_w-1:0]         prio,
  input  logic [num_of_ports-1:0]                req,
  input  logic [write_arb_pkg::select_width-1:0] start,
  output logic [write_arb_pkg::select_width-1:0] index,
  output logic                                   valid
);
  import write_arb_pkg::*;

  logic [prio_w-1:0]       prio_arr [num_of_ports];
  logic [prio_w-1:0]       best;
  logic [select_width-1:0] idx;
  int                      pos;

  for (genvar i = 0; i < num_of_ports; i++) begin : g_unpack
    assign prio_arr[i] = prio[i*prio_w +: prio_w];
  end

  // Walk in round-robin order; strict '>' keeps the earliest port on a tie.
  always_comb begin
    valid = 1'b0;
    index = '0;
    best  = '0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < num_of_ports; k++) begin
      pos = (int'(start) + k) % num_of_ports;
      idx = pos[select_width-1:0];
      if (req[idx] && (!valid || prio_arr[idx] > best)) begin
        valid = 1'b1;
        best  = prio_arr[idx];
        index = idx;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/write_port_selector.sv
// ----------------------------------------------------------------------------
// write_port_selector: grants the SRAM write path to one port per packet.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module write_port_selector #(
  parameter int num_of_ports      = 16,
  parameter int priority_width    = write_arb_pkg::priority_width,
  parameter int pack_length_width = write_arb_pkg::pack_length_width,
  parameter int timeout_cycles    = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [num_of_ports*priority_width-1:0] priority_in,
  input  logic [num_of_ports*priority_width-1:0] pre_priority_in,
  input  logic [num_of_ports*pack_length_width-1:0] pack_length_in,
  input  logic [num_of_ports-1:0]                ready,
  input  logic [num_of_ports-1:0]                wr_valid,
  input  logic [num_of_ports-1:0]                eop,
  output logic [write_arb_pkg::select_width-1:0] select,
  output logic [write_arb_pkg::select_width-1:0] pre_selected,
  output logic [num_of_ports-1:0]                grant,
  output logic                                   busy,
  output logic                                   len_err,
  output logic                                   timeout,
  output logic [write_arb_pkg::des_port_width-1:0] err_port
);
  import write_arb_pkg::*;

  localparam int                      lw1       = pack_length_width + 1;
  localparam logic [15:0]             wd_limit  = 16'(timeout_cycles - 1);
  localparam logic [select_width-1:0] last_port = select_width'(num_of_ports - 1);

  arb_state_t                   state;
  logic [select_width-1:0]      rr_ptr;
  logic [pack_length_width-1:0] beat_cnt;
  logic [15:0]                  wd_cnt;
  logic [select_width-1:0]      arb_idx, pre_idx;
  logic                         arb_valid, pre_valid;
  logic [pack_length_width-1:0] len_arr [num_of_ports];
  logic [pack_length_width-1:0] sel_len;
  logic [lw1-1:0]               beat_total;
  logic                         sel_valid, sel_eop;

  for (genvar i = 0; i < num_of_ports; i++) begin : g_len
    assign len_arr[i] = pack_length_in[i*pack_length_width +: pack_length_width];
  end

  assign sel_len    = len_arr[select];
  assign sel_valid  = wr_valid[select];
  assign sel_eop    = eop[select];
  assign beat_total = {1'b0, beat_cnt} + lw1'(1);

  prio_rr_pick #(.num_of_ports(num_of_ports), .prio_w(priority_width)) u_arb_pick (
    .prio(priority_in), .req(ready), .start(rr_ptr), .index(arb_idx), .valid(arb_valid)
  );

  prio_rr_pick #(.num_of_ports(num_of_ports), .prio_w(priority_width)) u_pre_pick (
    .prio(pre_priority_in), .req(ready), .start(rr_ptr), .index(pre_idx), .valid(pre_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      select       <= '0;
      pre_selected <= '0;
      grant        <= '0;
      busy         <= 1'b0;
      len_err      <= 1'b0;
      timeout      <= 1'b0;
      err_port     <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      wd_cnt       <= '0;
    end else begin
      len_err <= 1'b0;
      timeout <= 1'b0;
      if (pre_valid) pre_selected <= pre_idx;
      case (state)
        IDLE: if (|ready) begin
          state <= WAIT;
          busy  <= 1'b1;
        end
        WAIT: state <= ARB;
        ARB: if (arb_valid) begin
          select   <= arb_idx;
          grant    <= num_of_ports'(1) << arb_idx;
          rr_ptr   <= (arb_idx == last_port) ? '0 : arb_idx + 4'd1;
          beat_cnt <= '0;
          wd_cnt   <= '0;
          state    <= XFER;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        XFER: begin
          // End-of-packet takes precedence over a watchdog expiry in the same cycle.
          if (sel_valid && sel_eop) begin
            if (beat_total != {1'b0, sel_len} || sel_len == '0) begin
              len_err  <= 1'b1;
              err_port <= select;
            end
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else begin
            if (sel_valid && beat_cnt != '1) beat_cnt <= beat_total[pack_length_width-1:0];
            if (wd_cnt == wd_limit) begin
              timeout  <= 1'b1;
              err_port <= select;
              state    <= IDLE;
              grant    <= '0;
              busy     <= 1'b0;
            end else begin
              wd_cnt <= wd_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire
